// File: rtl/keylock_pkg.sv
// Constants and state encoding shared by the keypad entry and code-compare blocks.
package keylock_pkg;
  localparam int CODE_WIDTH = 32;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_BACK  = 4'hB;
  localparam logic [3:0] KEY_ENTER = 4'hC;

  typedef enum logic {
    IDLE    = 1'b0,
    REBUILD = 1'b1
  } state_t;
endpackage

// File: rtl/keypad_entry_if.sv
// Key-event handshake between the keypad scanner and the entry block.
interface keypad_entry_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;

  modport master (output key_valid, output key_code, input key_ready);
  modport slave  (input key_valid, input key_code, output key_ready);
endinterface

// File: rtl/mul10_add.sv
// Combinational x*10 + d, truncated to WIDTH bits.
module mul10_add #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic [3:0]       d,
  output logic [WIDTH-1:0] y
);
  assign y = (x << 3) + (x << 1) + {{(WIDTH-4){1'b0}}, d};
endmodule

// File: rtl/keypad_entry.sv
// Accumulates keypad digits into a binary code value; latches it on enter.
module keypad_entry
  import keylock_pkg::*;
#(
  parameter int WIDTH      = CODE_WIDTH,
  parameter int MAX_DIGITS = 9
) (
  input  logic             hwclk,
  input  logic             rst,
  keypad_entry_if.slave    key,
  output logic [WIDTH-1:0] entry,
  output logic [3:0]       digit_count,
  output logic [WIDTH-1:0] code,
  output logic             code_valid,
  output logic             overflow
);
  localparam logic [3:0] MAXD = 4'(MAX_DIGITS);

  state_t           state, state_d;
  logic [3:0]       digits_q [MAX_DIGITS];
  logic [WIDTH-1:0] acc;
  logic [3:0]       idx;
  logic [WIDTH-1:0] entry_push, acc_next;
  logic             accept, is_digit, rebuild_last;

  assign key.key_ready = (state == IDLE) && !rst;
  assign accept        = key.key_valid && key.key_ready;
  assign is_digit      = (key.key_code <= 4'd9);
  assign rebuild_last  = (idx == digit_count - 4'd1);

  mul10_add #(.WIDTH(WIDTH)) u_digit_path (
    .x(entry), .d(key.key_code), .y(entry_push)
  );

  mul10_add #(.WIDTH(WIDTH)) u_rebuild_path (
    .x(acc), .d(digits_q[idx]), .y(acc_next)
  );

  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept && key.key_code == KEY_BACK && digit_count >= 4'd2)
                 state_d = REBUILD;
      REBUILD: if (rebuild_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Buffer contents need no reset: digit_count bounds every read.
  always_ff @(posedge hwclk) begin
    if (accept && is_digit && digit_count != MAXD)
      digits_q[digit_count] <= key.key_code;
  end

  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      entry       <= '0;
      digit_count <= '0;
      code        <= '0;
      code_valid  <= 1'b0;
      overflow    <= 1'b0;
      acc         <= '0;
      idx         <= '0;
    end else begin
      code_valid <= 1'b0;
      overflow   <= 1'b0;
      if (state == REBUILD) begin
        // Replay the surviving digits oldest-first; entry only moves on the last pass.
        acc <= acc_next;
        idx <= idx + 4'd1;
        if (rebuild_last) entry <= acc_next;
      end else if (accept) begin
        if (is_digit) begin
          if (digit_count == MAXD) begin
            overflow <= 1'b1;
          end else begin
            entry       <= entry_push;
            digit_count <= digit_count + 4'd1;
          end
        end else begin
          case (key.key_code)
            KEY_CLEAR: begin
              entry       <= '0;
              digit_count <= '0;
            end
            KEY_ENTER: begin
              code        <= entry;
              code_valid  <= 1'b1;
              entry       <= '0;
              digit_count <= '0;
            end
            KEY_BACK: begin
              if (digit_count == 4'd1) begin
                entry       <= '0;
                digit_count <= '0;
              end else if (digit_count >= 4'd2) begin
                digit_count <= digit_count - 4'd1;
                acc         <= '0;
                idx         <= '0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: vector table plus multi-cycle corner sequences.
module tb_keypad_entry;
  import keylock_pkg::*;

  logic        hwclk = 1'b0;
  logic        rst   = 1'b1;
  logic [31:0] entry, code;
  logic [3:0]  digit_count;
  logic        code_valid, overflow;

  keypad_entry_if kif ();

  keypad_entry #(.WIDTH(32), .MAX_DIGITS(9)) dut (
    .hwclk(hwclk), .rst(rst), .key(kif.slave),
    .entry(entry), .digit_count(digit_count), .code(code),
    .code_valid(code_valid), .overflow(overflow)
  );

  always #5 hwclk = ~hwclk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        v;
    logic [3:0]  k;
    logic [31:0] e_entry;
    logic [3:0]  e_cnt;
    logic [31:0] e_code;
    logic        e_cv;
    logic        e_ov;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [3:0] k);
    @(negedge hwclk);
    kif.key_valid = v;
    kif.key_code  = k;
    @(posedge hwclk);
    #1;
  endtask

  initial begin
    int low;
    kif.key_valid = 1'b0;
    kif.key_code  = 4'h0;

    tbl[0]  = '{1'b1, 4'h5, 32'd5,      4'd1, 32'd0,      1'b0, 1'b0};
    tbl[1]  = '{1'b1, 4'h5, 32'd55,     4'd2, 32'd0,      1'b0, 1'b0};
    tbl[2]  = '{1'b1, 4'h5, 32'd555,    4'd3, 32'd0,      1'b0, 1'b0};
    tbl[3]  = '{1'b1, 4'h1, 32'd5551,   4'd4, 32'd0,      1'b0, 1'b0};
    tbl[4]  = '{1'b1, 4'h1, 32'd55511,  4'd5, 32'd0,      1'b0, 1'b0};
    tbl[5]  = '{1'b1, 4'h6, 32'd555116, 4'd6, 32'd0,      1'b0, 1'b0};
    tbl[6]  = '{1'b1, 4'hC, 32'd0,      4'd0, 32'd555116, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 4'h0, 32'd0,      4'd0, 32'd555116, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 4'h4, 32'd4,      4'd1, 32'd555116, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 4'h2, 32'd42,     4'd2, 32'd555116, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 4'hA, 32'd0,      4'd0, 32'd555116, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 4'hC, 32'd0,      4'd0, 32'd0,      1'b1, 1'b0};
    tbl[12] = '{1'b1, 4'hB, 32'd0,      4'd0, 32'd0,      1'b0, 1'b0};
    tbl[13] = '{1'b1, 4'h1, 32'd1,      4'd1, 32'd0,      1'b0, 1'b0};
    tbl[14] = '{1'b1, 4'hE, 32'd1,      4'd1, 32'd0,      1'b0, 1'b0};
    tbl[15] = '{1'b1, 4'h2, 32'd12,     4'd2, 32'd0,      1'b0, 1'b0};
    tbl[16] = '{1'b1, 4'hA, 32'd0,      4'd0, 32'd0,      1'b0, 1'b0};

    // Reset state
    #12;
    chk("rst_entry", entry, 0);
    chk("rst_count", 32'(digit_count), 0);
    chk("rst_code", code, 0);
    chk("rst_cv", 32'(code_valid), 0);
    chk("rst_ov", 32'(overflow), 0);
    chk("rst_ready_low", 32'(kif.key_ready), 0);
    @(negedge hwclk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(kif.key_ready), 1);

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].v, tbl[i].k);
      chk($sformatf("v%0d_entry", i), entry, tbl[i].e_entry);
      chk($sformatf("v%0d_count", i), 32'(digit_count), 32'(tbl[i].e_cnt));
      chk($sformatf("v%0d_code", i), code, tbl[i].e_code);
      chk($sformatf("v%0d_cv", i), 32'(code_valid), 32'(tbl[i].e_cv));
      chk($sformatf("v%0d_ov", i), 32'(overflow), 32'(tbl[i].e_ov));
      chk($sformatf("v%0d_ready", i), 32'(kif.key_ready), 1);
    end

    // Backspace from six digits, with a key held during the busy window
    step(1'b1, 4'h5); step(1'b1, 4'h5); step(1'b1, 4'h5);
    step(1'b1, 4'h1); step(1'b1, 4'h1); step(1'b1, 4'h6);
    step(1'b1, 4'hB);
    kif.key_code = 4'h7;
    chk("bs_count_now", 32'(digit_count), 5);
    chk("bs_entry_hold", entry, 555116);
    low = 0;
    while (kif.key_ready == 1'b0 && low < 20) begin
      low++;
      @(posedge hwclk);
      #1;
      if (kif.key_ready == 1'b0 && low == 4) chk("bs_entry_hold_late", entry, 555116);
    end
    kif.key_valid = 1'b0;
    chk("bs_low_cycles", 32'(low), 5);
    chk("bs_entry", entry, 55511);
    chk("bs_count", 32'(digit_count), 5);
    step(1'b0, 4'h0);
    chk("bs_key_ignored", entry, 55511);

    // Overflow on the tenth 9
    step(1'b1, KEY_CLEAR);
    for (int i = 0; i < 9; i++) step(1'b1, 4'h9);
    chk("ov_entry9", entry, 999999999);
    chk("ov_count9", 32'(digit_count), 9);
    chk("ov_none_yet", 32'(overflow), 0);
    step(1'b1, 4'h9);
    chk("ov_pulse", 32'(overflow), 1);
    chk("ov_entry_kept", entry, 999999999);
    chk("ov_count_kept", 32'(digit_count), 9);
    step(1'b0, 4'h0);
    chk("ov_pulse_end", 32'(overflow), 0);

    // Reset during the third REBUILD cycle
    step(1'b1, KEY_CLEAR);
    for (int i = 1; i <= 8; i++) step(1'b1, 4'(i));
    chk("rb_entry8", entry, 12345678);
    step(1'b1, KEY_BACK);
    kif.key_valid = 1'b0;
    @(posedge hwclk);
    @(posedge hwclk);
    #2;
    chk("rb_busy", 32'(kif.key_ready), 0);
    rst = 1'b1;
    #1;
    chk("rb_rst_entry", entry, 0);
    chk("rb_rst_count", 32'(digit_count), 0);
    chk("rb_rst_code", code, 0);
    chk("rb_rst_ready", 32'(kif.key_ready), 0);
    @(negedge hwclk);
    rst = 1'b0;
    #1;
    chk("rb_ready_back", 32'(kif.key_ready), 1);
    step(1'b1, 4'h7);
    chk("rb_entry7", entry, 7);
    chk("rb_count1", 32'(digit_count), 1);
    step(1'b0, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
